// File: rtl/pipeline_delay_stage.sv
// One register of the delay line.
// Synchronous active-high clear.
module pipeline_delay_stage #(
  parameter int Width = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/pipeline_delay.sv
// Fixed-latency delay line: q is d delayed Depth cycles.
// Depth=0 collapses to a plain wire.
module pipeline_delay #(
  parameter int          Width = 15,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  if (Width < 1) begin : g_bad_width
    $fatal(1, "pipeline_delay: Width must be >= 1");
  end

  if (Depth == 0) begin : g_wire
    assign q = d;
    // No flops here, so clk and rst go nowhere.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end else begin : g_pipe
    logic [Width-1:0] stage [Depth];

    for (genvar i = 0; i < Depth; i++) begin : g_stage
      if (i == 0) begin : g_first
        pipeline_delay_stage #(.Width(Width)) u_stage (
          .clk (clk),
          .rst (rst),
          .d   (d),
          .q   (stage[0])
        );
      end else begin : g_next
        pipeline_delay_stage #(.Width(Width)) u_stage (
          .clk (clk),
          .rst (rst),
          .d   (stage[i-1]),
          .q   (stage[i])
        );
      end
    end

    assign q = stage[Depth-1];
  end

endmodule

// File: tb/tb_pipeline_delay.sv
// Bench for pipeline_delay across several Depth/Width builds.
// Expected q comes from a history of sampled d and rst.
module tb_pipeline_delay;

  localparam int N    = 5;
  localparam int MAXC = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_v;
  logic [14:0]  dv [N];
  logic [14:0]  q0, q1, q2, q3;
  logic [0:0]   q4;

  logic         rst_z;
  logic [14:0]  d_z, q_z;

  pipeline_delay #(.Width(15), .Depth(2)) u_d2 (
    .clk(clk), .rst(rst_v[0]), .d(dv[0]), .q(q0));
  pipeline_delay #(.Width(15), .Depth(1)) u_d1 (
    .clk(clk), .rst(rst_v[1]), .d(dv[1]), .q(q1));
  pipeline_delay #(.Width(15), .Depth(5)) u_d5 (
    .clk(clk), .rst(rst_v[2]), .d(dv[2]), .q(q2));
  pipeline_delay #(.Width(15), .Depth(4)) u_d4 (
    .clk(clk), .rst(rst_v[3]), .d(dv[3]), .q(q3));
  pipeline_delay #(.Width(1), .Depth(3)) u_d3w1 (
    .clk(clk), .rst(rst_v[4]), .d(dv[4][0:0]), .q(q4));
  pipeline_delay #(.Width(15), .Depth(0)) u_d0 (
    .clk(clk), .rst(rst_z), .d(d_z), .q(q_z));

  logic [14:0] d_hist [N][MAXC];
  logic        r_hist [N][MAXC];
  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h, expected %h",
                  tag, cyc, got, exp);
  endtask

  function automatic int depth_of(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 5;
      3: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic [14:0] q_of(input int i);
    case (i)
      0: return q0;
      1: return q1;
      2: return q2;
      3: return q3;
      default: return {14'h0, q4};
    endcase
  endfunction

  function automatic string tag_of(input int i);
    case (i)
      0: return "d2";
      1: return "d1";
      2: return "d5";
      3: return "d4";
      default: return "d3w1";
    endcase
  endfunction

  // q after edge k: d from edge k-Depth+1, or 0 if any
  // reset edge fell within that window.
  function automatic logic [14:0] exp_q(input int i, input int k,
                                        output bit known);
    int dep;
    dep   = depth_of(i);
    known = 1'b1;
    for (int j = k; j >= k - dep + 1; j--) begin
      if (j < 0) begin
        known = 1'b0;
        return '0;
      end
      if (r_hist[i][j]) return '0;
    end
    return d_hist[i][k - dep + 1];
  endfunction

  task automatic step();
    bit known;
    logic [14:0] e;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      d_hist[i][cyc] = dv[i];
      r_hist[i][cyc] = rst_v[i];
    end
    #1;
    for (int i = 0; i < N; i++) begin
      e = exp_q(i, cyc, known);
      if (known) check(tag_of(i), {17'h0, q_of(i)}, {17'h0, e});
    end
    if (cyc < MAXC - 1) cyc++;
    else begin
      $display("FAIL cycle_budget: got %0d, expected < %0d",
               cyc, MAXC);
      n_chk++;
    end
  endtask

  function automatic logic [14:0] rnd15();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 15'h0000;
    if (r == 1) return 15'h7FFF;
    return 15'($urandom());
  endfunction

  initial begin
    rst_z = 1'b0;
    d_z   = '0;
    rst_v = '1;
    for (int i = 0; i < N; i++) dv[i] = '0;

    // Reset held 10 cycles with junk on d.
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 4; i++) dv[i] = rnd15();
      dv[4] = 15'($urandom_range(0, 1));
      step();
    end

    // First post-reset word on the Depth=2 build.
    rst_v = '0;
    dv[0] = 15'h1234;
    for (int i = 1; i < 4; i++) dv[i] = rnd15();
    dv[4] = 15'h0001;
    step();

    // Random stream; the Width=1 build toggles.
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 4; i++) dv[i] = rnd15();
      dv[4] = {14'h0, ~dv[4][0]};
      step();
    end

    // Counting stream on Depth=4, one reset cycle at item 8.
    for (int v = 1; v <= 16; v++) begin
      for (int i = 0; i < 3; i++) dv[i] = rnd15();
      dv[3]    = 15'(v);
      rst_v[3] = (v == 8);
      dv[4]    = {14'h0, ~dv[4][0]};
      step();
      if (v >= 8 && v <= 11) check("d4_flush", {17'h0, q3}, 32'h0);
    end
    rst_v[3] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++) dv[i] = rnd15();
      dv[4] = {14'h0, ~dv[4][0]};
      step();
    end

    // Depth=0 is a wire and ignores rst.
    d_z = 15'h7FFF; #1;
    check("d0_7fff", {17'h0, q_z}, 32'h7FFF);
    d_z = 15'h0000; #1;
    check("d0_0000", {17'h0, q_z}, 32'h0000);
    d_z = 15'h5555; #1;
    check("d0_5555", {17'h0, q_z}, 32'h5555);
    rst_z = 1'b1;
    @(posedge clk); #1;
    check("d0_rst", {17'h0, q_z}, 32'h5555);
    d_z = 15'h2AAA; #1;
    check("d0_rst_follow", {17'h0, q_z}, 32'h2AAA);
    rst_z = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
